// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, forward sources,
// and the operand/control fields driven into EX.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            hold_i;
    logic            flush_i;
    logic            id_valid_i;
    logic [XLEN-1:0] id_pc_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [RA_W-1:0] id_rs1_i;
    logic [RA_W-1:0] id_rs2_i;
    logic [RA_W-1:0] id_rd_i;
    logic            id_use_rs1_i;
    logic            id_use_rs2_i;
    logic [3:0]      id_alu_op_i;
    logic            id_src_pc_i;
    logic            id_src_imm_i;
    logic            id_reg_write_i;
    logic            id_mem_read_i;
    logic            id_mem_write_i;
    logic [RA_W-1:0] exm_rd_i;
    logic            exm_reg_write_i;
    logic [XLEN-1:0] exm_result_i;
    logic [RA_W-1:0] mwb_rd_i;
    logic            mwb_reg_write_i;
    logic [XLEN-1:0] mwb_result_i;

    logic            load_use_stall_o;
    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [3:0]      alu_op_o;
    logic [XLEN-1:0] store_data_o;
    logic            ex_valid_o;
    logic [RA_W-1:0] ex_rd_o;
    logic            ex_reg_write_o;
    logic            ex_mem_read_o;
    logic            ex_mem_write_o;
    logic [XLEN-1:0] ex_pc_o;

    modport master (
        output hold_i, flush_i, id_valid_i, id_pc_i,
        output id_rs1_data_i, id_rs2_data_i, id_imm_i,
        output id_rs1_i, id_rs2_i, id_rd_i,
        output id_use_rs1_i, id_use_rs2_i, id_alu_op_i,
        output id_src_pc_i, id_src_imm_i,
        output id_reg_write_i, id_mem_read_i, id_mem_write_i,
        output exm_rd_i, exm_reg_write_i, exm_result_i,
        output mwb_rd_i, mwb_reg_write_i, mwb_result_i,
        input  load_use_stall_o, alu_a_o, alu_b_o, alu_op_o,
        input  store_data_o, ex_valid_o, ex_rd_o,
        input  ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        input  ex_pc_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, id_pc_i,
        input  id_rs1_data_i, id_rs2_data_i, id_imm_i,
        input  id_rs1_i, id_rs2_i, id_rd_i,
        input  id_use_rs1_i, id_use_rs2_i, id_alu_op_i,
        input  id_src_pc_i, id_src_imm_i,
        input  id_reg_write_i, id_mem_read_i, id_mem_write_i,
        input  exm_rd_i, exm_reg_write_i, exm_result_i,
        input  mwb_rd_i, mwb_reg_write_i, mwb_result_i,
        output load_use_stall_o, alu_a_o, alu_b_o, alu_op_o,
        output store_data_o, ex_valid_o, ex_rd_o,
        output ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        output ex_pc_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and
// MEM/WB, plus load-use hazard detection toward IF/ID.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [3:0]      alu_op;
        logic            src_pc;
        logic            src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_t;

    ex_t ex_q, ex_d;

    logic            rs1_hit, rs2_hit, ld_use;
    logic            exm_a, exm_b, mwb_a, mwb_b;
    logic [XLEN-1:0] fwd_a, fwd_b;

    assign rs1_hit = bus.id_use_rs1_i && (bus.id_rs1_i == ex_q.rd);
    assign rs2_hit = bus.id_use_rs2_i && (bus.id_rs2_i == ex_q.rd);
    assign ld_use  = bus.id_valid_i && ex_q.valid && ex_q.mem_read
                   && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

    always_comb begin
        ex_d = ex_q;
        priority case (1'b1)
            bus.flush_i, ld_use && !bus.hold_i: begin
                ex_d        = '0;
                ex_d.alu_op = OP_ADD;
            end
            bus.hold_i: ex_d = ex_q;
            default: begin
                ex_d.valid     = bus.id_valid_i;
                ex_d.pc        = bus.id_pc_i;
                ex_d.rs1_data  = bus.id_rs1_data_i;
                ex_d.rs2_data  = bus.id_rs2_data_i;
                ex_d.imm       = bus.id_imm_i;
                ex_d.rs1       = bus.id_rs1_i;
                ex_d.rs2       = bus.id_rs2_i;
                ex_d.rd        = bus.id_rd_i;
                ex_d.alu_op    = bus.id_alu_op_i;
                ex_d.src_pc    = bus.id_src_pc_i;
                ex_d.src_imm   = bus.id_src_imm_i;
                ex_d.reg_write = bus.id_reg_write_i;
                ex_d.mem_read  = bus.id_mem_read_i;
                ex_d.mem_write = bus.id_mem_write_i;
                // An empty ID slot enters EX as a harmless ADD to x0.
                if (!bus.id_valid_i) begin
                    ex_d.reg_write = 1'b0;
                    ex_d.mem_read  = 1'b0;
                    ex_d.mem_write = 1'b0;
                    ex_d.alu_op    = OP_ADD;
                    ex_d.rd        = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign exm_a = bus.exm_reg_write_i && (bus.exm_rd_i != '0)
                 && (bus.exm_rd_i == ex_q.rs1);
    assign exm_b = bus.exm_reg_write_i && (bus.exm_rd_i != '0)
                 && (bus.exm_rd_i == ex_q.rs2);
    assign mwb_a = bus.mwb_reg_write_i && (bus.mwb_rd_i != '0)
                 && (bus.mwb_rd_i == ex_q.rs1);
    assign mwb_b = bus.mwb_reg_write_i && (bus.mwb_rd_i != '0)
                 && (bus.mwb_rd_i == ex_q.rs2);

    // The younger EX/MEM result wins over MEM/WB.
    assign fwd_a = exm_a ? bus.exm_result_i
                 : mwb_a ? bus.mwb_result_i
                 : ex_q.rs1_data;
    assign fwd_b = exm_b ? bus.exm_result_i
                 : mwb_b ? bus.mwb_result_i
                 : ex_q.rs2_data;

    assign bus.load_use_stall_o = ld_use;
    assign bus.alu_a_o          = ex_q.src_pc ? ex_q.pc : fwd_a;
    assign bus.alu_b_o          = ex_q.src_imm ? ex_q.imm : fwd_b;
    assign bus.alu_op_o         = ex_q.alu_op;
    assign bus.store_data_o     = fwd_b;
    assign bus.ex_valid_o       = ex_q.valid;
    assign bus.ex_rd_o          = ex_q.rd;
    assign bus.ex_reg_write_o   = ex_q.reg_write;
    assign bus.ex_mem_read_o    = ex_q.mem_read;
    assign bus.ex_mem_write_o   = ex_q.mem_write;
    assign bus.ex_pc_o          = ex_q.pc;
endmodule
